commutation_scheduler: RTL and testbench

- Per-output-phase modulation sequencer that drives the commutation FSM's DesiredLoad and CurrentSign inputs.
- Each switching period it connects the output phase to input phases A, B and C for programmed dwell counts. The downstream FSM performs the safe four-step commutation between connections.
- It also filters and freezes the current-sign input so that it cannot change while a commutation is in flight.
- One instance exists per output phase; three instances sit in front of the three commutation FSMs.

---
 rtl/commutation_pkg.sv | 44 ++++
 rtl/sign_filter.sv | 33 +++
 rtl/commutation_scheduler.sv | 147 ++++++++++++++
 tb/tb_commutation_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commutation_pkg.sv
// Shared types for the per-phase commutation scheduler.
// Load codes, sign encoding, scheduler states and segment helpers.
package commutation_pkg;

    typedef enum logic [1:0] {
        NUL = 2'b00,
        LAA = 2'b01,
        LBB = 2'b10,
        LCC = 2'b11
    } load_t;

    typedef enum logic {
        SIGN_NEG = 1'b0,
        SIGN_POS = 1'b1
    } sign_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEG1,
        SEG2,
        SEG3
    } state_t;

    // Segment slot to phase: forward A,B,C; reverse C,B,A.
    function automatic load_t seg_code(input state_t s, input logic rev);
        unique case (s)
            SEG1:    seg_code = rev ? LCC : LAA;
            SEG2:    seg_code = LBB;
            SEG3:    seg_code = rev ? LAA : LCC;
            default: seg_code = NUL;
        endcase
    endfunction

    // First non-empty slot in nz; otherwise the end-of-period target.
    function automatic state_t pick(input logic [2:0] nz, input logic go);
        if (nz[0])      pick = SEG1;
        else if (nz[1]) pick = SEG2;
        else if (nz[2]) pick = SEG3;
        else if (go)    pick = LOAD;
        else            pick = IDLE;
    endfunction

endpackage

// File: rtl/sign_filter.sv
// Current-sign debounce with a freeze input.
// The sign only moves after SIGN_FILT equal samples and while unfrozen.
module sign_filter #(
    parameter int SIGN_FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic freeze,
    output logic sign
);
    import commutation_pkg::*;

    logic [SIGN_FILT-1:0] sr;
    sign_t                cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cand <= SIGN_NEG;
            sign <= 1'b0;
        end else begin
            sr <= {sr[SIGN_FILT-2:0], raw};
            if (&sr)
                cand <= SIGN_POS;
            else if (~|sr)
                cand <= SIGN_NEG;
            if (!freeze)
                sign <= cand;
        end
    end

endmodule

// File: rtl/commutation_scheduler.sv
// Per-output-phase modulation sequencer feeding one commutation FSM.
// Runs A/B/C dwell segments each period, alternating direction.
module commutation_scheduler #(
    parameter int CNT_W     = 16,
    parameter int COMM_CYC  = 4,
    parameter int SIGN_FILT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    input  logic [CNT_W-1:0] duty_c,
    input  logic             cur_sign_raw,
    output logic [1:0]       desired_load,
    output logic             current_sign,
    output logic             period_start,
    output logic             busy,
    output logic             err
);
    import commutation_pkg::*;

    localparam int TW = $clog2(COMM_CYC + 1);

    state_t                  state, state_n;
    load_t                   dl, dl_n, dl_q;
    logic [2:0][CNT_W-1:0]   len, use_len, ord, fresh;
    logic [CNT_W-1:0]        cnt, cnt_n, res;
    logic [CNT_W+1:0]        sum;
    logic [TW-1:0]           timer;
    logic [2:0]              nz;
    logic                    rev, rev_n, use_rev, have;
    logic                    over, accept, freeze;

    // Candidate shadow: duties in run order, residue on the last non-zero slot.
    always_comb begin
        sum    = {2'b00, duty_a} + {2'b00, duty_b} + {2'b00, duty_c};
        over   = sum > {2'b00, period};
        accept = (period != '0) && !over;
        rev_n  = have ? ~rev : 1'b0;
        ord[0] = rev_n ? duty_c : duty_a;
        ord[1] = duty_b;
        ord[2] = rev_n ? duty_a : duty_c;
        res    = period - sum[CNT_W-1:0];
        fresh  = ord;
        if (ord[2] != '0)
            fresh[2] = ord[2] + res;
        else if (ord[1] != '0)
            fresh[1] = ord[1] + res;
        else
            fresh[0] = ord[0] + res;
    end

    always_comb begin
        state_n = state;
        use_len = len;
        use_rev = rev;
        if (state == LOAD && accept) begin
            use_len = fresh;
            use_rev = rev_n;
        end
        nz = {use_len[2] != '0, use_len[1] != '0, use_len[0] != '0};
        unique case (state)
            IDLE: if (en) state_n = LOAD;
            LOAD: begin
                if (period == '0 || (over && !have))
                    state_n = IDLE;
                else
                    state_n = pick(nz, en);
            end
            SEG1: if (cnt == '0) state_n = pick(nz & 3'b110, en);
            SEG2: if (cnt == '0) state_n = pick(nz & 3'b100, en);
            SEG3: if (cnt == '0) state_n = pick(3'b000, en);
            default: state_n = IDLE;
        endcase

        cnt_n = cnt;
        if (state_n != state) begin
            unique case (state_n)
                SEG1:    cnt_n = use_len[0] - 1'b1;
                SEG2:    cnt_n = use_len[1] - 1'b1;
                SEG3:    cnt_n = use_len[2] - 1'b1;
                default: cnt_n = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end

        dl_n = dl;
        if (state_n == IDLE)
            dl_n = NUL;
        else if (state_n != LOAD)
            dl_n = seg_code(state_n, use_rev);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            rev          <= 1'b0;
            have         <= 1'b0;
            dl           <= NUL;
            dl_q         <= NUL;
            timer        <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dl           <= dl_n;
            dl_q         <= dl;
            period_start <= (state == LOAD) && (state_n != IDLE);
            busy         <= state_n != IDLE;
            if (state == LOAD && over)
                err <= 1'b1;
            if (state == LOAD && accept) begin
                len  <= fresh;
                rev  <= rev_n;
                have <= 1'b1;
            end else if (state == IDLE) begin
                have <= 1'b0;
            end
            // Hold the sign through the whole four-step commutation.
            if (dl != dl_q)
                timer <= TW'(COMM_CYC);
            else if (timer != '0)
                timer <= timer - 1'b1;
        end
    end

    assign freeze       = (timer != '0) || (dl != dl_q);
    assign desired_load = dl;

    sign_filter #(
        .SIGN_FILT(SIGN_FILT)
    ) u_sign (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (cur_sign_raw),
        .freeze(freeze),
        .sign  (current_sign)
    );

endmodule

// File: tb/tb_commutation_scheduler.sv
// Scoreboard bench: expected load runs are queued, a monitor pops them.
// Directed checks cover reset, err, sign freeze and restart latency.
module tb_commutation_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] duty_a = '0;
    logic [15:0] duty_b = '0;
    logic [15:0] duty_c = '0;
    logic        raw = 1'b0;
    logic [1:0]  desired_load;
    logic        current_sign;
    logic        period_start;
    logic        busy;
    logic        err;

    typedef struct {
        logic [1:0] code;
        int         len;
    } run_t;

    run_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] prev = 2'b00;
    int         run = 0;
    int         n;

    commutation_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period      (period),
        .duty_a      (duty_a),
        .duty_b      (duty_b),
        .duty_c      (duty_c),
        .cur_sign_raw(raw),
        .desired_load(desired_load),
        .current_sign(current_sign),
        .period_start(period_start),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Monitor: every finished non-null run of desired_load is scored.
    always @(negedge clk) begin
        run_t e;
        if (!rst_n) begin
            prev = 2'b00;
            run  = 0;
        end else if (desired_load != prev) begin
            if (prev != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL run: got %0d x%0d, none expected", prev, run);
                end else begin
                    e = exp_q.pop_front();
                    if (e.code !== prev || e.len != run) begin
                        errors++;
                        $display("FAIL run: got %0d x%0d expected %0d x%0d",
                                 prev, run, e.code, e.len);
                    end
                end
            end
            prev = desired_load;
            run  = 1;
        end else begin
            run++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] code, input int len);
        run_t e;
        e.code = code;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input int p, input int a, input int b, input int c);
        period = 16'(p);
        duty_a = 16'(a);
        duty_b = 16'(b);
        duty_c = 16'(c);
    endtask

    task automatic wait_ps(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_start && cyc < 200);
        if (!period_start) begin
            errors++;
            $display("FAIL wait_ps: got no pulse, required one within 200");
        end
    endtask

    task automatic wait_dl(input logic [1:0] code);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (desired_load !== code && k < 200);
        chk("wait_load", desired_load, code);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 200);
        chk("idle_busy", busy, 0);
        chk("idle_load", desired_load, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load", desired_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sign", current_sign, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Two periods forward then reverse; en drops in the second.
        cfg(10, 3, 3, 4);
        push(2'b01, 3); push(2'b10, 3); push(2'b11, 9);
        push(2'b10, 3); push(2'b01, 3);
        en = 1'b1;
        wait_ps(n);
        chk("start_latency", n, 3);
        wait_ps(n);
        chk("period_gap", n, 11);
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle();

        // Zero B duty skipped, residue on C.
        cfg(12, 5, 0, 3);
        push(2'b01, 5); push(2'b11, 7);
        @(posedge clk);
        #1 en = 1'b1;
        wait_ps(n);
        chk("restart_latency", n, 3);
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle();

        // Overflowing duties rejected, old pattern repeats, err sticks.
        cfg(10, 3, 3, 4);
        push(2'b01, 3); push(2'b10, 3); push(2'b11, 5);
        push(2'b01, 3); push(2'b10, 3); push(2'b11, 8);
        push(2'b01, 9);
        @(posedge clk);
        #1 en = 1'b1;
        wait_ps(n);
        chk("err_before", err, 0);
        @(posedge clk);
        #1 cfg(8, 5, 5, 0);
        wait_ps(n);
        chk("err_set", err, 1);
        chk("err_old_gap", n, 11);
        @(posedge clk);
        #1 cfg(12, 5, 0, 3);
        wait_ps(n);
        chk("err_recover_gap", n, 11);
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle();
        chk("err_sticky", err, 1);

        // Sign filter against the commutation freeze.
        cfg(40, 4, 30, 6);
        push(2'b01, 4); push(2'b10, 30); push(2'b11, 6);
        @(posedge clk);
        #1 en = 1'b1;
        wait_dl(2'b10);
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 raw = 1'b1;
        repeat (5) @(negedge clk);
        chk("sign_hold", current_sign, 0);
        @(negedge clk);
        chk("sign_rise", current_sign, 1);
        repeat (21) @(posedge clk);
        #1 raw = 1'b0;
        repeat (8) @(negedge clk);
        chk("sign_freeze_wins", current_sign, 1);
        @(negedge clk);
        chk("sign_fall", current_sign, 0);
        wait_idle();
        @(posedge clk);
        #1 raw = 1'b1;
        @(posedge clk);
        #1 raw = 1'b0;
        repeat (8) @(negedge clk);
        chk("sign_glitch", current_sign, 0);

        // Asynchronous reset in SEG2, then restart forward from A.
        @(posedge clk);
        #1 raw = 1'b1;
        repeat (10) @(negedge clk);
        chk("sign_idle", current_sign, 1);
        cfg(10, 3, 3, 4);
        push(2'b01, 3);
        @(posedge clk);
        #1 en = 1'b1;
        wait_dl(2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_load", desired_load, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sign", current_sign, 0);
        chk("arst_err", err, 0);
        push(2'b01, 3); push(2'b10, 3); push(2'b11, 4);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ps(n);
        chk("arst_restart", n, 3);
        @(posedge clk);
        #1 en = 1'b0;
        wait_idle();

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
